// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// One transaction in flight at a time; a watchdog forces an error response if memory stalls.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ifu_req_valid,
  output logic          ifu_req_ready,
  input  logic [AW-1:0] ifu_addr,
  output logic          ifu_resp_valid,
  input  logic          ifu_resp_ready,
  output logic [DW-1:0] ifu_rdata,
  input  logic          lsu_req_valid,
  output logic          lsu_req_ready,
  input  logic [AW-1:0] lsu_addr,
  input  logic          lsu_wen,
  input  logic [2:0]    lsu_memop,
  input  logic [DW-1:0] lsu_wdata,
  output logic          lsu_resp_valid,
  input  logic          lsu_resp_ready,
  output logic [DW-1:0] lsu_rdata,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wen,
  output logic [2:0]    mem_memop,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_resp_valid,
  output logic          mem_resp_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic            last_lsu_r;
  logic            owner_lsu_r;
  logic [AW-1:0]   addr_r;
  logic            wen_r;
  logic [2:0]      memop_r;
  logic [DW-1:0]   wdata_r;
  logic [DW-1:0]   rdata_r;
  logic [CW-1:0]   wd_cnt_r;
  logic            err_r;
  logic            gnt_ifu_s;
  logic            gnt_lsu_s;
  logic            timeout_s;
  logic            owner_ready_s;

  // The port that did not win last time takes a tie.
  assign gnt_ifu_s     = ifu_req_valid && (!lsu_req_valid || last_lsu_r);
  assign gnt_lsu_s     = lsu_req_valid && (!ifu_req_valid || !last_lsu_r);
  assign timeout_s     = (wd_cnt_r == CW'(TIMEOUT - 1));
  assign owner_ready_s = owner_lsu_r ? lsu_resp_ready : ifu_resp_ready;

  assign ifu_req_ready  = rst_n && (state_r == IDLE) && gnt_ifu_s;
  assign lsu_req_ready  = rst_n && (state_r == IDLE) && gnt_lsu_s;
  assign mem_req_valid  = (state_r == ISSUE);
  assign mem_resp_ready = (state_r == WAIT);
  assign mem_addr       = addr_r;
  assign mem_wen        = wen_r;
  assign mem_memop      = memop_r;
  assign mem_wdata      = wdata_r;
  assign ifu_resp_valid = (state_r == RESP) && !owner_lsu_r;
  assign lsu_resp_valid = (state_r == RESP) && owner_lsu_r;
  assign ifu_rdata      = ifu_resp_valid ? rdata_r : {DW{1'b0}};
  assign lsu_rdata      = lsu_resp_valid ? rdata_r : {DW{1'b0}};
  assign err            = err_r;

  // Next-state decode for the transaction sequence.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_ifu_s || gnt_lsu_s) state_nx_s = ISSUE;
        else                        state_nx_s = IDLE;
      end
      ISSUE: begin
        if (mem_req_ready) state_nx_s = WAIT;
        else               state_nx_s = ISSUE;
      end
      WAIT: begin
        if (mem_resp_valid || timeout_s) state_nx_s = RESP;
        else                             state_nx_s = WAIT;
      end
      RESP: begin
        if (owner_ready_s) state_nx_s = IDLE;
        else               state_nx_s = RESP;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nx_s;
  end

  // Request capture, watchdog and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_lsu_r  <= 1'b1;
      owner_lsu_r <= 1'b0;
      addr_r      <= {AW{1'b0}};
      wen_r       <= 1'b0;
      memop_r     <= 3'b000;
      wdata_r     <= {DW{1'b0}};
      rdata_r     <= {DW{1'b0}};
      wd_cnt_r    <= {CW{1'b0}};
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt_ifu_s || gnt_lsu_s) begin
            owner_lsu_r <= gnt_lsu_s;
            last_lsu_r  <= gnt_lsu_s;
            addr_r      <= gnt_lsu_s ? lsu_addr : ifu_addr;
            wen_r       <= gnt_lsu_s && lsu_wen;
            memop_r     <= gnt_lsu_s ? lsu_memop : 3'b010;
            wdata_r     <= gnt_lsu_s ? lsu_wdata : {DW{1'b0}};
          end
        end
        ISSUE: begin
          if (mem_req_ready) wd_cnt_r <= {CW{1'b0}};
        end
        WAIT: begin
          wd_cnt_r <= wd_cnt_r + CW'(1);
          if (mem_resp_valid) begin
            rdata_r <= wen_r ? {DW{1'b0}} : mem_rdata;
          end else if (timeout_s) begin
            rdata_r <= {DW{1'b0}};
            err_r   <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_req_valid = 1'b0, ifu_resp_ready = 1'b0;
  logic [31:0] ifu_addr = 32'd0;
  logic        lsu_req_valid = 1'b0, lsu_wen = 1'b0, lsu_resp_ready = 1'b0;
  logic [2:0]  lsu_memop = 3'd0;
  logic [31:0] lsu_addr = 32'd0, lsu_wdata = 32'd0;
  logic        mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid;
  logic [31:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata;
  logic        mem_req_valid, mem_wen, mem_resp_ready, err;
  logic [2:0]  mem_memop;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_memop(lsu_memop), .lsu_wdata(lsu_wdata),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_memop(mem_memop), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata),
    .err(err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one in-flight transaction with progress flags.
  bit          m_active, m_issued, m_answered, m_lsu, m_wen, m_err, m_pref_ifu;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_memop;
  int          m_waited;

  function automatic bit pick_lsu();
    return lsu_req_valid && !(ifu_req_valid && m_pref_ifu);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_issued <= 1'b0; m_answered <= 1'b0; m_lsu <= 1'b0;
      m_wen <= 1'b0; m_err <= 1'b0; m_pref_ifu <= 1'b1; m_waited <= 0;
      m_addr <= 32'd0; m_wdata <= 32'd0; m_rdata <= 32'd0; m_memop <= 3'd0;
    end else if (!m_active) begin
      if (ifu_req_valid || lsu_req_valid) begin
        m_active   <= 1'b1;
        m_lsu      <= pick_lsu();
        m_pref_ifu <= pick_lsu();
        m_addr     <= pick_lsu() ? lsu_addr : ifu_addr;
        m_wen      <= pick_lsu() && lsu_wen;
        m_memop    <= pick_lsu() ? lsu_memop : 3'b010;
        m_wdata    <= lsu_wdata;
      end
    end else if (!m_issued) begin
      if (mem_req_ready) begin
        m_issued <= 1'b1;
        m_waited <= 0;
      end
    end else if (!m_answered) begin
      if (mem_resp_valid) begin
        m_answered <= 1'b1;
        m_rdata    <= m_wen ? 32'd0 : mem_rdata;
      end else if (m_waited + 1 == TO) begin
        m_answered <= 1'b1;
        m_rdata    <= 32'd0;
        m_err      <= 1'b1;
      end else begin
        m_waited <= m_waited + 1;
      end
    end else if (m_lsu ? lsu_resp_ready : ifu_resp_ready) begin
      m_active <= 1'b0; m_issued <= 1'b0; m_answered <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ifu_req_ready", 32'(ifu_req_ready),
          32'(rst_n && !m_active && ifu_req_valid && (!lsu_req_valid || m_pref_ifu)));
      chk("lsu_req_ready", 32'(lsu_req_ready),
          32'(rst_n && !m_active && lsu_req_valid && (!ifu_req_valid || !m_pref_ifu)));
      chk("mem_req_valid", 32'(mem_req_valid), 32'(m_active && !m_issued));
      chk("mem_resp_ready", 32'(mem_resp_ready), 32'(m_issued && !m_answered));
      chk("ifu_resp_valid", 32'(ifu_resp_valid), 32'(m_answered && !m_lsu));
      chk("lsu_resp_valid", 32'(lsu_resp_valid), 32'(m_answered && m_lsu));
      chk("err", 32'(err), 32'(m_err));
      if (m_active && !m_issued) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wen", 32'(mem_wen), 32'(m_wen));
        chk("mem_memop", 32'(mem_memop), 32'(m_memop));
        if (m_wen) chk("mem_wdata", mem_wdata, m_wdata);
      end
      if (m_answered && m_lsu)  chk("lsu_rdata", lsu_rdata, m_rdata);
      if (m_answered && !m_lsu) chk("ifu_rdata", ifu_rdata, m_rdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Returns at the negedge on which the chosen port sees req_ready.
  task automatic wait_ready(input bit lsu, input string nm);
    bit got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (lsu ? lsu_req_ready : ifu_req_ready) got = 1'b1;
      else step();
    end
    chk(nm, 32'(got), 32'd1);
  endtask

  task automatic drain();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
    ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
    repeat (8) step();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
    step();
  endtask

  int order[$];

  initial begin
    step();
    cmp_en = 1'b1;
    step();
    chk("rst_ifu_req_ready", 32'(ifu_req_ready), 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    step();

    // Single IFU fetch, memory answers immediately.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0413;
    wait_ready(1'b0, "t1_ready");
    step();
    ifu_req_valid = 1'b0;
    @(negedge clk);
    chk("t1_mem_addr", mem_addr, 32'h8000_0000);
    chk("t1_mem_memop", 32'(mem_memop), 32'd2);
    step();
    @(negedge clk);
    chk("t1_resp_early", 32'(ifu_resp_valid), 32'd0);
    step();
    @(negedge clk);
    chk("t1_resp_valid", 32'(ifu_resp_valid), 32'd1);
    chk("t1_rdata", ifu_rdata, 32'h0000_0413);
    chk("t1_lsu_resp", 32'(lsu_resp_valid), 32'd0);
    drain();

    // Both ports always requesting: grants alternate, IFU first after reset.
    do_reset();
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
    ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_wen = 1'b0;
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      @(negedge clk);
      if (ifu_req_ready) order.push_back(0);
      if (lsu_req_ready) order.push_back(1);
      step();
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    chk("t2_grants", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size(); i++) chk("t2_order", 32'(order[i]), 32'(i % 2));
    drain();

    // LSU store with memory stalling the request for 3 cycles.
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
    lsu_memop = 3'b010; lsu_wdata = 32'h1234_5678;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    wait_ready(1'b1, "t3_ready");
    step();
    lsu_req_valid = 1'b0; lsu_addr = 32'hFFFF_FFFF; lsu_wdata = 32'd0; lsu_memop = 3'b111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t3_req_valid", 32'(mem_req_valid), 32'd1);
      chk("t3_wen", 32'(mem_wen), 32'd1);
      chk("t3_addr", mem_addr, 32'h8000_1000);
      chk("t3_wdata", mem_wdata, 32'h1234_5678);
      chk("t3_memop", 32'(mem_memop), 32'd2);
      if (c < 2) step();
    end
    step();
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_req_ready = 1'b0;
    step();
    mem_resp_valid = 1'b0;
    // Owner holds off the response while IFU is waiting to get in.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t4_resp_valid", 32'(lsu_resp_valid), 32'd1);
      chk("t4_rdata", lsu_rdata, 32'd0);
      chk("t4_no_ready", 32'(ifu_req_ready), 32'd0);
      step();
    end
    lsu_resp_ready = 1'b1;
    step();
    lsu_resp_ready = 1'b0;
    @(negedge clk);
    chk("t4_ready_after", 32'(ifu_req_ready), 32'd1);
    drain();

    // Memory never answers: watchdog fires after TO wait cycles.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0020;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
    wait_ready(1'b0, "t5_ready");
    step();
    ifu_req_valid = 1'b0;
    for (int c = 0; c < TO; c++) begin
      step();
      @(negedge clk);
      chk("t5_waiting", 32'(ifu_resp_valid), 32'd0);
      chk("t5_resp_ready", 32'(mem_resp_ready), 32'd1);
    end
    step();
    @(negedge clk);
    chk("t5_resp_valid", 32'(ifu_resp_valid), 32'd1);
    chk("t5_rdata", ifu_rdata, 32'd0);
    chk("t5_err", 32'(err), 32'd1);
    drain();
    chk("t5_err_sticky", 32'(err), 32'd1);

    // Asynchronous reset in the middle of WAIT.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0030;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
    wait_ready(1'b0, "t6_ready");
    step();
    ifu_req_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_mem_resp_ready", 32'(mem_resp_ready), 32'd0);
    chk("t6_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("t6_resp_valid", 32'({ifu_resp_valid, lsu_resp_valid}), 32'd0);
    chk("t6_rdata", ifu_rdata | lsu_rdata, 32'd0);
    chk("t6_mem_addr", mem_addr, 32'd0);
    chk("t6_err", 32'(err), 32'd0);
    step();
    rst_n = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
    mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_0001;
    wait_ready(1'b0, "t6_ready2");
    step();
    ifu_req_valid = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("t6_resp_valid2", 32'(ifu_resp_valid), 32'd1);
    chk("t6_rdata2", ifu_rdata, 32'hCAFE_0001);
    chk("t6_err2", 32'(err), 32'd0);
    drain();

    // Randomized traffic, with periodic silent windows long enough to trip the watchdog.
    for (int c = 0; c < 3000; c++) begin
      ifu_req_valid  = 1'($urandom_range(0, 1));
      ifu_addr       = $urandom;
      lsu_req_valid  = 1'($urandom_range(0, 1));
      lsu_addr       = $urandom;
      lsu_wen        = 1'($urandom_range(0, 1));
      lsu_memop      = 3'($urandom_range(0, 7));
      lsu_wdata      = $urandom;
      ifu_resp_ready = ($urandom_range(0, 2) != 0);
      lsu_resp_ready = ($urandom_range(0, 2) != 0);
      mem_req_ready  = ($urandom_range(0, 2) != 0);
      mem_resp_valid = ((c % 64) < 12) ? 1'b0 : ($urandom_range(0, 3) != 0);
      mem_rdata      = $urandom;
      if (c == 1500) rst_n = 1'b0;
      if (c == 1503) rst_n = 1'b1;
      step();
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
